// File: rtl/zero_indices_multi.sv
// zero_indices_multi
// Loads a W-bit vector, selects either its zero bits or its one bits, and
// streams the selected bit positions out in ascending order, up to N
// indices per response beat, with a valid/ready handshake on both sides.
module zero_indices_multi #(
    parameter int W  = 32,
    parameter int N  = 4,
    localparam int IW = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_vector,
    input  logic            in_find_ones,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [N-1:0]    resp_lane_vld,
    output logic [N*IW-1:0] resp_index,
    output logic            resp_last,
    output logic            busy_r,
    output logic            done_r
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           done_q, done_d;

    logic [N-1:0]    lane_vld;
    logic [N*IW-1:0] lane_idx;
    logic [W-1:0]    clr_mask;
    logic [W-1:0]    rest_mask;
    logic [W-1:0]    load_mask;
    logic            beat_last;
    logic            accept;
    logic            beat_fire;

    // Pick the N lowest pending bits; lane k gets the (k+1)-th lowest index.
    always_comb begin
        int found;
        lane_vld = '0;
        lane_idx = '0;
        clr_mask = '0;
        found    = 0;
        for (int b = 0; b < W; b++) begin
            if (pend_q[b] && (found < N)) begin
                lane_vld[found]          = 1'b1;
                lane_idx[found*IW +: IW] = IW'(b);
                clr_mask[b]              = 1'b1;
                found                    = found + 1;
            end
        end
    end

    // The current beat is final when nothing remains after clearing its bits.
    always_comb begin
        rest_mask = pend_q & ~clr_mask;
        beat_last = (rest_mask == '0);
        load_mask = in_find_ones ? in_vector : ~in_vector;
    end

    // Handshake qualifiers; loading is only possible while idle.
    always_comb begin
        accept    = in_valid && (state_q == IDLE);
        beat_fire = (state_q == BUSY) && resp_ready;
    end

    // Next-state logic: load on accept, retire reported bits on each beat.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_d = load_mask;
                    if (load_mask != '0) begin
                        state_d = BUSY;
                    end else begin
                        // Nothing selected: finish immediately without a beat.
                        done_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (beat_fire) begin
                    pend_d = rest_mask;
                    if (beat_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending mask and completion pulse; reset discards any work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    // Outputs are driven straight from registered state, gated by BUSY.
    always_comb begin
        busy_r        = (state_q == BUSY);
        done_r        = done_q;
        in_ready      = ~busy_r;
        resp_valid    = busy_r;
        resp_lane_vld = busy_r ? lane_vld : '0;
        resp_index    = busy_r ? lane_idx : '0;
        resp_last     = busy_r & beat_last;
    end

endmodule

// File: tb/tb_zero_indices_multi.sv
// Directed bench for zero_indices_multi at W=8, N=2.
module tb_zero_indices_multi;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_vector;
    logic            in_find_ones;
    logic            resp_valid;
    logic            resp_ready;
    logic [N-1:0]    resp_lane_vld;
    logic [N*IW-1:0] resp_index;
    logic            resp_last;
    logic            busy_r;
    logic            done_r;

    zero_indices_multi #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vector    (in_vector),
        .in_find_ones (in_find_ones),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_lane_vld(resp_lane_vld),
        .resp_index   (resp_index),
        .resp_last    (resp_last),
        .busy_r       (busy_r),
        .done_r       (done_r)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] vld;
        logic [5:0] idx;   // {lane1, lane0}
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [7:0]      vec;
        logic            fo;
        logic [2:0]      nb;
        beat_t [3:0]     beats;
    } rec_t;

    rec_t tbl[$];
    int   ncmp = 0;
    int   nfail = 0;

    function automatic beat_t bt(input logic [1:0] vld, input int i1, input int i0,
                                 input logic last);
        beat_t b;
        b.vld  = vld;
        b.idx  = {3'(i1), 3'(i0)};
        b.last = last;
        return b;
    endfunction

    task automatic add_vec(input logic [7:0] vec, input logic fo, input int nb,
                           input beat_t b0, input beat_t b1);
        rec_t r;
        r.vec      = vec;
        r.fo       = fo;
        r.nb       = 3'(nb);
        r.beats[0] = b0;
        r.beats[1] = b1;
        r.beats[2] = '0;
        r.beats[3] = '0;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one vector; returns in the cycle where done_r is high so the
    // next call accepts back-to-back.
    task automatic run_vec(input rec_t r, input int id);
        string tag;
        tag = $sformatf("v%0d", id);
        in_vector    = r.vec;
        in_find_ones = r.fo;
        in_valid     = 1'b1;
        resp_ready   = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid     = 1'b0;
        in_vector    = ~r.vec;       // must be ignored after accept
        in_find_ones = ~r.fo;
        for (int k = 0; k < int'(r.nb); k++) begin
            chk($sformatf("%s.b%0d.valid", tag, k), 32'(resp_valid), 32'd1);
            chk($sformatf("%s.b%0d.vld", tag, k), 32'(resp_lane_vld), 32'(r.beats[k].vld));
            chk($sformatf("%s.b%0d.idx", tag, k), 32'(resp_index), 32'(r.beats[k].idx));
            chk($sformatf("%s.b%0d.last", tag, k), 32'(resp_last), 32'(r.beats[k].last));
            chk($sformatf("%s.b%0d.rdy_busy_done", tag, k),
                32'({in_ready, busy_r, done_r}), 32'b010);
            step();
        end
        chk({tag, ".done"}, 32'(done_r), 32'd1);
        chk({tag, ".idle"}, 32'({resp_valid, busy_r, in_ready}), 32'b001);
    endtask

    initial begin
        logic [N*IW-1:0] hold_idx;

        add_vec(8'hB2, 1'b0, 2, bt(2'b11, 2, 0, 1'b0), bt(2'b11, 6, 3, 1'b1));
        add_vec(8'hB2, 1'b1, 2, bt(2'b11, 4, 1, 1'b0), bt(2'b11, 7, 5, 1'b1));
        add_vec(8'hFF, 1'b0, 0, '0, '0);
        add_vec(8'hFE, 1'b0, 1, bt(2'b01, 0, 0, 1'b1), '0);
        add_vec(8'h00, 1'b1, 0, '0, '0);
        add_vec(8'h80, 1'b1, 1, bt(2'b01, 0, 7, 1'b1), '0);
        add_vec(8'h55, 1'b1, 2, bt(2'b11, 2, 0, 1'b0), bt(2'b11, 6, 4, 1'b1));
        add_vec(8'h07, 1'b1, 2, bt(2'b11, 1, 0, 1'b0), bt(2'b01, 0, 2, 1'b1));

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_vector    = '0;
        in_find_ones = 1'b0;
        resp_ready   = 1'b1;
        #1;
        chk("reset.outputs", 32'({busy_r, done_r, resp_valid, resp_last, resp_lane_vld}), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Table vectors, applied back-to-back.
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end
        step();
        chk("after_tbl.done_clear", 32'(done_r), 32'd0);

        // All-zero vector with each beat stalled three cycles.
        in_vector    = 8'h00;
        in_find_ones = 1'b0;
        in_valid     = 1'b1;
        resp_ready   = 1'b0;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            hold_idx = {3'(2*b+1), 3'(2*b)};
            for (int s = 0; s < 4; s++) begin
                in_vector = 8'(s * 37 + b);
                chk($sformatf("stall.b%0d.s%0d.valid", b, s), 32'(resp_valid), 32'd1);
                chk($sformatf("stall.b%0d.s%0d.vld", b, s), 32'(resp_lane_vld), 32'b11);
                chk($sformatf("stall.b%0d.s%0d.idx", b, s), 32'(resp_index), 32'(hold_idx));
                chk($sformatf("stall.b%0d.s%0d.last", b, s), 32'(resp_last), 32'(b == 3));
                chk($sformatf("stall.b%0d.s%0d.done", b, s), 32'(done_r), 32'd0);
                resp_ready = (s == 3);
                step();
                resp_ready = 1'b0;
            end
        end
        chk("stall.done", 32'(done_r), 32'd1);
        chk("stall.idle", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1;
        step();

        // Reset in the middle of an enumeration.
        in_vector = 8'h00;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rstmid.b0.idx", 32'(resp_index), 32'({3'd1, 3'd0}));
        step();
        chk("rstmid.b1.idx", 32'(resp_index), 32'({3'd3, 3'd2}));
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid.async", 32'({resp_valid, busy_r, done_r, resp_last, resp_lane_vld}), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rstmid.no_done", 32'(done_r), 32'd0);
        chk("rstmid.in_ready", 32'({in_ready, resp_valid}), 32'b10);

        // Fresh vector after reset works normally.
        run_vec(tbl[0], 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
